// File: rtl/mem_responder_if.sv
// Memory-port bundle between the core (master) and mem_responder (slave).
// Handshake: the master holds exactly one of mem_read/mem_write with stable fields until mem_resp pulses for one cycle.
interface mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-array memory responder for the multicycle core's memory port.
// Optional request-stability checker enabled by defining MEM_RESPONDER_PROTOCOL_CHECK_EN.
module mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus,
  output logic            protocol_err,
  output logic [1:0]      state_dbg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);
  localparam int         DEPTH    = 2 ** ADDR_WIDTH;

  logic [1:0]            state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] cap_idx;
  logic                  cap_we;
  logic [3:0]            cap_be;
  logic [31:0]           cap_wdata;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_array [DEPTH];

  logic                  req_ok;
  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic                  op_we;
  logic [3:0]            op_be;
  logic [31:0]           op_wdata;

  assign req_ok    = bus.mem_read ^ bus.mem_write;
  assign req_idx   = bus.mem_address[ADDR_WIDTH+1:2];
  assign state_dbg = state;
  assign bus.mem_resp  = (state == RESP);
  assign bus.mem_rdata = rdata_q;

  // Commit happens on the edge that enters RESP; with LATENCY=1 that is the
  // capture edge itself, so the live request fields are used directly.
  always_comb begin
    commit   = 1'b0;
    op_idx   = cap_idx;
    op_we    = cap_we;
    op_be    = cap_be;
    op_wdata = cap_wdata;
    if (state == IDLE && req_ok && LATENCY == 1) begin
      commit   = rst;
      op_idx   = req_idx;
      op_we    = bus.mem_write;
      op_be    = bus.mem_byte_enable;
      op_wdata = bus.mem_wdata;
    end else if (state == BUSY && cnt == 4'd1) begin
      commit = rst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      cap_idx   <= '0;
      cap_we    <= 1'b0;
      cap_be    <= 4'd0;
      cap_wdata <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_ok) begin
            cap_idx   <= req_idx;
            cap_we    <= bus.mem_write;
            cap_be    <= bus.mem_byte_enable;
            cap_wdata <= bus.mem_wdata;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= LAT_INIT;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (commit && !op_we) rdata_q <= mem_array[op_idx];
    end
  end

  // Array contents survive reset; only the commit gating protects them.
  always_ff @(posedge clk) begin
    if (commit && op_we) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) mem_array[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
  logic req_changed;

  always_comb begin
    req_changed = (bus.mem_read != !cap_we) || (bus.mem_write != cap_we) ||
                  (req_idx != cap_idx) || (bus.mem_byte_enable != cap_be) ||
                  (bus.mem_wdata != cap_wdata);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      protocol_err <= 1'b0;
    end else if ((state == BUSY && req_changed) ||
                 (state == IDLE && bus.mem_read && bus.mem_write)) begin
      protocol_err <= 1'b1;
    end
  end
`else
  assign protocol_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_WIDTH=10, LATENCY=3).
// Expected protocol_err behaviour follows MEM_RESPONDER_PROTOCOL_CHECK_EN.
module tb_mem_responder;
  localparam int ADDR_WIDTH = 10;
  localparam int LATENCY    = 3;
`ifdef MEM_RESPONDER_PROTOCOL_CHECK_EN
  localparam logic [31:0] ERR_ON = 32'd1;
`else
  localparam logic [31:0] ERR_ON = 32'd0;
`endif

  logic       clk;
  logic       rst;
  logic       protocol_err;
  logic [1:0] state_dbg;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [31:0] exp_q[$];

  mem_responder_if bus ();

  mem_responder #(.ADDR_WIDTH(ADDR_WIDTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .protocol_err (protocol_err),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_byte_enable = 4'd0;
    bus.mem_address     = 32'h0;
    bus.mem_wdata       = 32'h0;
  endtask

  // Driver: issue one request, optionally disturb the address during BUSY,
  // measure latency, and compare read data against the scoreboard head.
  task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd, input logic glitch);
    int n;
    logic [31:0] exp;
    @(negedge clk);
    bus.mem_read        = !wr;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (glitch && n == 1) bus.mem_address = addr + 32'd4;
    end while (!bus.mem_resp && n < 20);
    check({tag, "_latency"}, 32'(n), 32'(LATENCY));
    if (!wr && bus.mem_resp) begin
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
      check({tag, "_rdata"}, bus.mem_rdata, exp);
    end
    idle_bus();
  endtask

  initial begin
    logic saw_resp;
    idle_bus();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_resp", 32'(bus.mem_resp), 32'd0);
    check("reset_rdata", bus.mem_rdata, 32'h0);
    check("reset_err", 32'(protocol_err), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    rst = 1'b1;

    // Full-word write then read back
    do_req("t1_wr", 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF, 1'b0);
    exp_q.push_back(32'hDEADBEEF);
    do_req("t1_rd", 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);

    // Single-lane write; low address bits ignored
    do_req("t2_wr", 1'b1, 32'h101, 4'b0010, 32'h0000AB00, 1'b0);
    check("t2_rdata_held", bus.mem_rdata, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADABEF);
    do_req("t2_rd", 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);

    // Aliasing above ADDR_WIDTH+2 bits
    do_req("t3_wr", 1'b1, 32'h100, 4'b1111, 32'h12345678, 1'b0);
    exp_q.push_back(32'h12345678);
    do_req("t3_rd", 1'b0, 32'h1103, 4'b0000, 32'h0, 1'b0);

    // Empty byte enable: completes, array untouched
    do_req("t3_be0", 1'b1, 32'h100, 4'b0000, 32'hFFFFFFFF, 1'b0);

    // Both read and write high: ignored
    @(negedge clk);
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_address = 32'h100;
    bus.mem_byte_enable = 4'b1111;
    bus.mem_wdata = 32'h0BADF00D;
    saw_resp = 1'b0;
    repeat (10) begin
      @(negedge clk);
      saw_resp |= bus.mem_resp;
    end
    check("t4_no_resp", 32'(saw_resp), 32'd0);
    check("t4_state_idle", 32'(state_dbg), 32'd0);
    check("t4_err", 32'(protocol_err), ERR_ON);
    idle_bus();
    exp_q.push_back(32'h12345678);
    do_req("t4_rd", 1'b0, 32'h100, 4'b0000, 32'h0, 1'b0);

    // Reset during BUSY aborts an uncommitted write
    do_req("t5_pre", 1'b1, 32'h200, 4'b1111, 32'h11112222, 1'b0);
    @(negedge clk);
    bus.mem_write = 1'b1;
    bus.mem_address = 32'h200;
    bus.mem_byte_enable = 4'b1111;
    bus.mem_wdata = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    check("t5_busy", 32'(state_dbg), 32'd1);
    rst = 1'b0;
    #1;
    check("t5_rst_resp", 32'(bus.mem_resp), 32'd0);
    check("t5_rst_rdata", bus.mem_rdata, 32'h0);
    check("t5_rst_err", 32'(protocol_err), 32'd0);
    @(negedge clk);
    idle_bus();
    rst = 1'b1;
    exp_q.push_back(32'h11112222);
    do_req("t5_rd", 1'b0, 32'h200, 4'b0000, 32'h0, 1'b0);

    // Address changed mid-BUSY: captured address still served
    do_req("t6_pre", 1'b1, 32'h104, 4'b1111, 32'h55AA55AA, 1'b0);
    check("t6_err_clear", 32'(protocol_err), 32'd0);
    exp_q.push_back(32'h12345678);
    do_req("t6_rd", 1'b0, 32'h100, 4'b0000, 32'h0, 1'b1);
    check("t6_err", 32'(protocol_err), ERR_ON);
    repeat (3) @(negedge clk);
    check("t6_err_held", 32'(protocol_err), ERR_ON);
    check("t6_rdata_held", bus.mem_rdata, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
